// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS subset core: one FSM-sequenced datapath sharing a single req/ready memory port.
// Defining MIPS_MC_BNE_EN adds bne (op 05h); without it that opcode traps.
module mips_multi_cycle #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           pc,
    output logic                  instr_retired,
    output logic                  illegal_instr
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTEXEC, ALUWB, ADDIEX, BRANCH, JUMP, TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

`ifdef MIPS_MC_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    state_t      state_r;
    logic [31:0] pc_r, ir_r, a_r, b_r, aluout_r, mdr_r;
    logic [31:0] mem_addr_r, mem_wdata_r;
    logic        mem_req_r, mem_we_r, retired_r, illegal_r;
    logic [31:0] rf_r [0:31];

    logic [5:0]  op_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, rf_waddr_s;
    logic [31:0] sext_s, alu_s, addr_sum_s, pc_next_s, rs_val_s, rt_val_s, rf_wdata_s;
    logic        take_s, go_fetch_s, rf_we_s;
    state_t      dec_s;

    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] funct);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = MEMADR;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = RTEXEC;
                    default: nxt = TRAP;
                endcase
            end
            OP_BEQ:  nxt = BRANCH;
            OP_BNE:  nxt = BNE_EN ? BRANCH : TRAP;
            OP_ADDI: nxt = ADDIEX;
            OP_J:    nxt = JUMP;
            default: nxt = TRAP;
        endcase
        return nxt;
    endfunction

    assign op_s     = ir_r[31:26];
    assign rs_s     = ir_r[25:21];
    assign rt_s     = ir_r[20:16];
    assign rd_s     = ir_r[15:11];
    assign funct_s  = ir_r[5:0];
    assign sext_s   = {{16{ir_r[15]}}, ir_r[15:0]};
    assign rs_val_s = (rs_s == 5'd0) ? 32'd0 : rf_r[rs_s];
    assign rt_val_s = (rt_s == 5'd0) ? 32'd0 : rf_r[rt_s];
    assign dec_s    = decode_next(op_s, funct_s);

    // Datapath: ALU, branch decision, register write port and the PC value taking effect at this edge.
    always_comb begin
        case (funct_s)
            FN_ADD:  alu_s = a_r + b_r;
            FN_SUB:  alu_s = a_r - b_r;
            FN_AND:  alu_s = a_r & b_r;
            FN_OR:   alu_s = a_r | b_r;
            FN_SLT:  alu_s = {31'd0, $signed(a_r) < $signed(b_r)};
            default: alu_s = 32'd0;
        endcase
        addr_sum_s = a_r + sext_s;
        take_s     = (a_r == b_r) ^ (BNE_EN && (op_s == OP_BNE));
        pc_next_s  = pc_r;
        go_fetch_s = 1'b0;
        rf_we_s    = 1'b0;
        rf_waddr_s = rt_s;
        rf_wdata_s = aluout_r;
        case (state_r)
            FETCH: begin
                if (mem_req_r && mem_ready) pc_next_s = pc_r + 32'd4;
                else                        pc_next_s = pc_r;
            end
            MEMWB: begin
                go_fetch_s = 1'b1;
                rf_we_s    = 1'b1;
                rf_wdata_s = mdr_r;
            end
            ALUWB: begin
                go_fetch_s = 1'b1;
                rf_we_s    = 1'b1;
                rf_waddr_s = (op_s == OP_RTYPE) ? rd_s : rt_s;
            end
            MEMWR: begin
                if (mem_ready) go_fetch_s = 1'b1;
                else           go_fetch_s = 1'b0;
            end
            BRANCH: begin
                go_fetch_s = 1'b1;
                if (take_s) pc_next_s = aluout_r;
                else        pc_next_s = pc_r;
            end
            JUMP: begin
                go_fetch_s = 1'b1;
                pc_next_s  = {pc_r[31:28], ir_r[25:0], 2'b00};
            end
            default: pc_next_s = pc_r;
        endcase
    end

    // Register file write port; $0 writes are dropped and contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && rf_we_s && (rf_waddr_s != 5'd0)) rf_r[rf_waddr_s] <= rf_wdata_s;
    end

    // Control FSM with registered memory-port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= FETCH;
            pc_r        <= RESET_PC;
            ir_r        <= 32'd0;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            aluout_r    <= 32'd0;
            mdr_r       <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {RESET_PC[31:2], 2'b00};
            mem_wdata_r <= 32'd0;
            retired_r   <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            pc_r      <= pc_next_s;
            retired_r <= go_fetch_s;
            case (state_r)
                FETCH: begin
                    // Only the first fetch after reset arrives here with the request still low.
                    if (!mem_req_r) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {pc_r[31:2], 2'b00};
                    end else if (mem_ready) begin
                        ir_r      <= mem_rdata;
                        mem_req_r <= 1'b0;
                        state_r   <= DECODE;
                    end
                end
                DECODE: begin
                    a_r      <= rs_val_s;
                    b_r      <= rt_val_s;
                    aluout_r <= pc_r + {sext_s[29:0], 2'b00};
                    state_r  <= dec_s;
                    if (dec_s == TRAP) illegal_r <= 1'b1;
                end
                MEMADR: begin
                    aluout_r    <= addr_sum_s;
                    mem_req_r   <= 1'b1;
                    mem_addr_r  <= {addr_sum_s[31:2], 2'b00};
                    mem_wdata_r <= b_r;
                    if (op_s == OP_LW) begin
                        mem_we_r <= 1'b0;
                        state_r  <= MEMRD;
                    end else begin
                        mem_we_r <= 1'b1;
                        state_r  <= MEMWR;
                    end
                end
                MEMRD: begin
                    if (mem_ready) begin
                        mdr_r     <= mem_rdata;
                        mem_req_r <= 1'b0;
                        state_r   <= MEMWB;
                    end
                end
                MEMWR:                       state_r <= mem_ready ? FETCH : MEMWR;
                MEMWB, ALUWB, BRANCH, JUMP:  state_r <= FETCH;
                RTEXEC: begin
                    aluout_r <= alu_s;
                    state_r  <= ALUWB;
                end
                ADDIEX: begin
                    aluout_r <= addr_sum_s;
                    state_r  <= ALUWB;
                end
                TRAP: begin
                    mem_req_r <= 1'b0;
                    illegal_r <= 1'b1;
                    state_r   <= TRAP;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    illegal_r <= 1'b1;
                    state_r   <= TRAP;
                end
            endcase
            if (go_fetch_s) begin
                state_r    <= FETCH;
                mem_req_r  <= 1'b1;
                mem_we_r   <= 1'b0;
                mem_addr_r <= {pc_next_s[31:2], 2'b00};
            end
        end
    end

    assign mem_req       = mem_req_r;
    assign mem_we        = mem_we_r;
    assign mem_addr      = mem_addr_r[MEM_ADDR_W-1:0];
    assign mem_wdata     = mem_wdata_r;
    assign pc            = pc_r;
    assign instr_retired = retired_r;
    assign illegal_instr = illegal_r;

endmodule

// File: tb/tb_mips_multi_cycle.sv
// Directed bench for mips_multi_cycle: a wait-state memory model, transaction log and retire timing.
// Phase 3 expectations follow MIPS_MC_BNE_EN, so run the bench in both builds.
module tb_mips_multi_cycle;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] ILL    = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, instr_retired, illegal_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0, errors = 0, cyc = 0, waits = 0, wait_cnt = 0, stable_err = 0;
    logic [31:0] mem [0:255];
    bit          acc = 1'b0, in_wait = 1'b0;
    logic        acc_we = 1'b0, hold_we = 1'b0;
    logic [31:0] acc_addr = 32'd0, acc_wdata = 32'd0, hold_addr = 32'd0, hold_wdata = 32'd0;
    logic [31:0] q_addr[$], q_data[$];
    logic        q_we[$];
    int          retire_cyc[$];

    int p1_cpi [9] = '{4, 4, 4, 4, 4, 4, 4, 3, 3};
    int p2_cpi [4] = '{10, 11, 10, 11};

    always #5 clk = ~clk;

    mips_multi_cycle #(.RESET_PC(RST_PC), .MEM_ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .instr_retired(instr_retired), .illegal_instr(illegal_instr)
    );

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle seen from the falling edge: log retires, complete/serve memory transactions.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (instr_retired) retire_cyc.push_back(cyc);
        if (acc) begin
            if (acc_we) mem[acc_addr[9:2]] = acc_wdata;
            q_addr.push_back(acc_addr);
            q_we.push_back(acc_we);
            q_data.push_back(acc_we ? acc_wdata : 32'd0);
            acc = 1'b0;
            wait_cnt = 0;
            in_wait = 1'b0;
        end
        if (mem_req && !reset) begin
            if (in_wait && (mem_addr != hold_addr || mem_we != hold_we || (mem_we && mem_wdata != hold_wdata)))
                stable_err++;
            in_wait = 1'b1;
            hold_addr = mem_addr;
            hold_we = mem_we;
            hold_wdata = mem_wdata;
            if (wait_cnt >= waits) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                acc = 1'b1;
                acc_we = mem_we;
                acc_addr = mem_addr;
                acc_wdata = mem_wdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_DEAD;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt = 0;
            in_wait = 1'b0;
            acc = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check("req_in_reset", {31'd0, mem_req}, 32'd0);
        end
        reset = 1'b0;
        q_addr.delete();
        q_we.delete();
        q_data.delete();
        retire_cyc.delete();
        stable_err = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = ILL;
    endtask

    task automatic run_until_trap(input int max);
        int n = 0;
        while (!illegal_instr && n < max) begin
            tick();
            n++;
        end
        check("trap_reached", {31'd0, illegal_instr}, 32'd1);
    endtask

    task automatic expect_txn(input int idx, input logic we, input logic [31:0] addr, input logic [31:0] data);
        check($sformatf("txn%0d_addr", idx), q_addr[idx], addr);
        check($sformatf("txn%0d_we", idx), {31'd0, q_we[idx]}, {31'd0, we});
        if (we) check($sformatf("txn%0d_wdata", idx), q_data[idx], data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_req;

        // Phase 1: reset, arithmetic, stores, $0, jump and branch, illegal opcode; zero wait states.
        clear_mem();
        mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[66] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[67] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
        mem[68] = enc_r(5'd1, 5'd1, 5'd0, 6'h20);
        mem[69] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        mem[70] = enc_i(6'h2B, 5'd0, 5'd4, 16'd12);
        mem[71] = enc_i(6'h2B, 5'd0, 5'd0, 16'd16);
        mem[72] = {6'h02, 26'h000_0008};
        mem[8]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        waits = 0;
        do_reset(3);
        tick();
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h100);
        tick();
        check("pc_after_fetch", pc, 32'h104);
        run_until_trap(400);
        check("p1_txn_count", q_addr.size(), 32'd14);
        expect_txn(0, 1'b0, 32'h100, 32'd0);
        expect_txn(4, 1'b0, 32'h110, 32'd0);
        expect_txn(6, 1'b1, 32'h008, 32'd2);
        expect_txn(8, 1'b1, 32'h00C, 32'd1);
        expect_txn(10, 1'b1, 32'h010, 32'd0);
        expect_txn(11, 1'b0, 32'h120, 32'd0);
        expect_txn(12, 1'b0, 32'h020, 32'd0);
        expect_txn(13, 1'b0, 32'h02C, 32'd0);
        check("p1_retires", retire_cyc.size(), 32'd10);
        for (int i = 0; i < 9; i++)
            check($sformatf("p1_cpi%0d", i + 1), retire_cyc[i + 1] - retire_cyc[i], p1_cpi[i]);
        check("trap_pc", pc, 32'h030);
        idle_req = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req) idle_req++;
        end
        check("trap_no_req", idle_req, 32'd0);
        check("trap_sticky", {31'd0, illegal_instr}, 32'd1);
        do_reset(2);
        tick();
        check("illegal_cleared", {31'd0, illegal_instr}, 32'd0);
        check("refetch_addr", mem_addr, 32'h100);

        // Phase 2: store/load with three wait states per access and a misaligned lw address.
        clear_mem();
        mem[2]  = 32'hDEAD_BEEF;
        mem[64] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
        mem[65] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        mem[66] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
        mem[67] = enc_i(6'h2B, 5'd0, 5'd5, 16'd20);
        mem[68] = enc_i(6'h23, 5'd0, 5'd6, 16'd11);
        waits = 3;
        do_reset(2);
        run_until_trap(500);
        check("p2_txn_count", q_addr.size(), 32'd10);
        expect_txn(2, 1'b1, 32'h008, 32'd2);
        expect_txn(4, 1'b0, 32'h008, 32'd0);
        expect_txn(6, 1'b1, 32'h014, 32'd2);
        expect_txn(8, 1'b0, 32'h008, 32'd0);
        check("p2_retires", retire_cyc.size(), 32'd5);
        for (int i = 0; i < 4; i++)
            check($sformatf("p2_cpi%0d", i + 1), retire_cyc[i + 1] - retire_cyc[i], p2_cpi[i]);
        check("hs_stable", stable_err, 32'd0);

        // Phase 3: bne with unequal operands.
        clear_mem();
        mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[66] = enc_i(6'h05, 5'd1, 5'd2, 16'd1);
        waits = 0;
        do_reset(2);
        run_until_trap(300);
`ifdef MIPS_MC_BNE_EN
        check("p3_fetches", q_addr.size(), 32'd4);
        check("p3_bne_target", q_addr[3], 32'h110);
        check("p3_pc", pc, 32'h114);
`else
        check("p3_fetches", q_addr.size(), 32'd3);
        check("p3_pc", pc, 32'h10C);
`endif

        // Phase 4: j 0x40 loops back to 0x100.
        clear_mem();
        mem[64] = {6'h02, 26'h000_0040};
        do_reset(2);
        for (int i = 0; i < 12; i++) tick();
        check("p4_enough", {31'd0, q_addr.size() >= 3}, 32'd1);
        check("p4_jump1", q_addr[1], 32'h100);
        check("p4_jump2", q_addr[2], 32'h100);
        check("p4_cpi", retire_cyc[1] - retire_cyc[0], 32'd3);
        check("p4_no_trap", {31'd0, illegal_instr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
